// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter_if
// Brief    : Bundle of the writeback, multdiv, IO and register-file write
//            signals shared between the write arbiter and its neighbours.
// Revision : 1.0  initial release
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Pipeline writeback
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_stall;
    // Multiply/divide completion
    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0] md_data;
    // IO/sensor capture
    logic              io_valid;
    logic              io_ready;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_data;
    // Register file write port
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;

    // Requesters and register file side
    modport master (
        output wb_we, wb_addr, wb_data,
        input  wb_stall,
        output md_valid, md_addr, md_data,
        input  md_ready,
        output io_valid, io_addr, io_data,
        input  io_ready,
        input  rf_we, rf_addr, rf_data
    );

    // Arbiter side
    modport slave (
        input  wb_we, wb_addr, wb_data,
        output wb_stall,
        input  md_valid, md_addr, md_data,
        output md_ready,
        input  io_valid, io_addr, io_data,
        output io_ready,
        output rf_we, rf_addr, rf_data
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Shares the single register-file write port between writeback,
//            multdiv and IO. md/io each own a one-entry buffer; an aged-out
//            buffer stalls writeback so it cannot be starved.
// Revision : 1.0  initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int AGE_W        = 3
) (
    input  logic                clk,
    input  logic                reset,
    rf_write_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_MD   = 2'd2,
        GNT_IO   = 2'd3
    } grant_t;

    localparam logic [AGE_W-1:0]  AGE_MAX   = AGE_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

    // Buffer state
    logic              md_buf_valid_q, md_buf_valid_d;
    logic [ADDR_W-1:0] md_addr_q;
    logic [DATA_W-1:0] md_data_q;
    logic [AGE_W-1:0]  md_age_q, md_age_d;
    logic              io_buf_valid_q, io_buf_valid_d;
    logic [ADDR_W-1:0] io_addr_q;
    logic [DATA_W-1:0] io_data_q;
    logic [AGE_W-1:0]  io_age_q, io_age_d;

    // Output stage
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    grant_t grant;
    logic   md_starved, io_starved, starve;
    logic   md_load, io_load;

    assign md_starved = md_buf_valid_q && (md_age_q == AGE_MAX);
    assign io_starved = io_buf_valid_q && (io_age_q == AGE_MAX);
    assign starve     = md_starved || io_starved;

    // Ready only when empty, so a buffer drained this cycle cannot refill at the same edge.
    assign bus.md_ready = !md_buf_valid_q;
    assign bus.io_ready = !io_buf_valid_q;
    assign bus.wb_stall = starve;

    // Handshakes to address 0 complete but are dropped on the floor.
    assign md_load = bus.md_valid && !md_buf_valid_q && (bus.md_addr != ADDR_ZERO);
    assign io_load = bus.io_valid && !io_buf_valid_q && (bus.io_addr != ADDR_ZERO);

    // Fixed-priority grant: starved buffers, then writeback, then plain buffers.
    always_comb begin
        grant = GNT_NONE;
        if (md_starved) begin
            grant = GNT_MD;
        end else if (io_starved) begin
            grant = GNT_IO;
        end else if (bus.wb_we && (bus.wb_addr != ADDR_ZERO)) begin
            grant = GNT_WB;
        end else if (md_buf_valid_q) begin
            grant = GNT_MD;
        end else if (io_buf_valid_q) begin
            grant = GNT_IO;
        end
    end

    // Buffer occupancy and ageing; empty or just-granted buffers sit at age 0.
    always_comb begin
        md_buf_valid_d = md_buf_valid_q;
        io_buf_valid_d = io_buf_valid_q;
        md_age_d       = md_age_q;
        io_age_d       = io_age_q;

        if (grant == GNT_MD) md_buf_valid_d = 1'b0;
        if (md_load)         md_buf_valid_d = 1'b1;
        if (grant == GNT_IO) io_buf_valid_d = 1'b0;
        if (io_load)         io_buf_valid_d = 1'b1;

        if (!md_buf_valid_q || (grant == GNT_MD)) begin
            md_age_d = '0;
        end else if (md_age_q < AGE_MAX) begin
            md_age_d = md_age_q + AGE_W'(1);
        end

        if (!io_buf_valid_q || (grant == GNT_IO)) begin
            io_age_d = '0;
        end else if (io_age_q < AGE_MAX) begin
            io_age_d = io_age_q + AGE_W'(1);
        end
    end

    // Write port mux; address/data hold their last value when idle.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        unique case (grant)
            GNT_WB: begin
                rf_we_d   = 1'b1;
                rf_addr_d = bus.wb_addr;
                rf_data_d = bus.wb_data;
            end
            GNT_MD: begin
                rf_we_d   = 1'b1;
                rf_addr_d = md_addr_q;
                rf_data_d = md_data_q;
            end
            GNT_IO: begin
                rf_we_d   = 1'b1;
                rf_addr_d = io_addr_q;
                rf_data_d = io_data_q;
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
    end

    // Buffer and output registers; reset discards pending writes at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_buf_valid_q <= 1'b0;
            md_addr_q      <= '0;
            md_data_q      <= '0;
            md_age_q       <= '0;
            io_buf_valid_q <= 1'b0;
            io_addr_q      <= '0;
            io_data_q      <= '0;
            io_age_q       <= '0;
            rf_we_q        <= 1'b0;
            rf_addr_q      <= '0;
            rf_data_q      <= '0;
        end else begin
            md_buf_valid_q <= md_buf_valid_d;
            md_age_q       <= md_age_d;
            io_buf_valid_q <= io_buf_valid_d;
            io_age_q       <= io_age_d;
            if (md_load) begin
                md_addr_q <= bus.md_addr;
                md_data_q <= bus.md_data;
            end
            if (io_load) begin
                io_addr_q <= bus.io_addr;
                io_data_q <= bus.io_data;
            end
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign bus.rf_we   = rf_we_q;
    assign bus.rf_addr = rf_addr_q;
    assign bus.rf_data = rf_data_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Directed self-checking bench for rf_write_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    rf_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_write_arbiter #(
        .DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4), .AGE_W(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running, required finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_we    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.md_valid = 1'b0;
        bus.md_addr  = '0;
        bus.md_data  = '0;
        bus.io_valid = 1'b0;
        bus.io_addr  = '0;
        bus.io_data  = '0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // 1. Reset state
        chk("rst_rf_we",    bus.rf_we,    1'b0);
        chk("rst_rf_addr",  bus.rf_addr,  5'd0);
        chk("rst_rf_data",  bus.rf_data,  32'd0);
        chk("rst_md_ready", bus.md_ready, 1'b1);
        chk("rst_io_ready", bus.io_ready, 1'b1);
        chk("rst_wb_stall", bus.wb_stall, 1'b0);

        // 2. Writeback single write, one-cycle latency
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd3;
        bus.wb_data = 32'hDEADBEEF;
        tick();
        idle();
        chk("wb_rf_we",   bus.rf_we,   1'b1);
        chk("wb_rf_addr", bus.rf_addr, 5'd3);
        chk("wb_rf_data", bus.rf_data, 32'hDEADBEEF);
        tick();
        chk("wb_idle_we",   bus.rf_we,   1'b0);
        chk("wb_hold_addr", bus.rf_addr, 5'd3);

        // 3. md and io offered together, md wins
        bus.md_valid = 1'b1; bus.md_addr = 5'd7; bus.md_data = 32'h12;
        bus.io_valid = 1'b1; bus.io_addr = 5'd9; bus.io_data = 32'h34;
        #1;
        chk("hs_md_ready_pre", bus.md_ready, 1'b1);
        tick();
        idle();
        chk("hs_md_ready_full", bus.md_ready, 1'b0);
        chk("hs_io_ready_full", bus.io_ready, 1'b0);
        chk("hs_no_write_yet",  bus.rf_we,    1'b0);
        tick();
        chk("md_rf_we",    bus.rf_we,    1'b1);
        chk("md_rf_addr",  bus.rf_addr,  5'd7);
        chk("md_rf_data",  bus.rf_data,  32'h12);
        chk("md_ready_back", bus.md_ready, 1'b1);
        chk("io_still_full", bus.io_ready, 1'b0);
        tick();
        chk("io_rf_we",   bus.rf_we,   1'b1);
        chk("io_rf_addr", bus.rf_addr, 5'd9);
        chk("io_rf_data", bus.rf_data, 32'h34);
        chk("io_ready_back", bus.io_ready, 1'b1);
        chk("md_ready_c4",   bus.md_ready, 1'b1);
        tick();
        chk("after_io_idle", bus.rf_we, 1'b0);

        // 4. md starved by continuous writeback
        bus.md_valid = 1'b1; bus.md_addr = 5'd5; bus.md_data = 32'hAA;
        tick();
        idle();
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd2;
        for (int k = 1; k <= 4; k++) begin
            bus.wb_data = 32'(k);
            #1;
            chk($sformatf("starve_nostall_%0d", k), bus.wb_stall, 1'b0);
            tick();
            chk($sformatf("starve_wb_addr_%0d", k), bus.rf_addr, 5'd2);
            chk($sformatf("starve_wb_data_%0d", k), bus.rf_data, 32'(k));
        end
        bus.wb_data = 32'd5;
        #1;
        chk("starve_stall_hi", bus.wb_stall, 1'b1);
        tick();
        chk("starve_md_we",   bus.rf_we,   1'b1);
        chk("starve_md_addr", bus.rf_addr, 5'd5);
        chk("starve_md_data", bus.rf_data, 32'hAA);
        chk("starve_stall_lo", bus.wb_stall, 1'b0);
        tick();
        chk("resume_wb_addr", bus.rf_addr, 5'd2);
        chk("resume_wb_data", bus.rf_data, 32'd5);
        idle();
        tick();
        chk("resume_idle", bus.rf_we, 1'b0);

        // 5. Address 0 writes are dropped
        bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFF;
        tick();
        idle();
        chk("wb_a0_no_we", bus.rf_we, 1'b0);
        bus.md_valid = 1'b1; bus.md_addr = 5'd0; bus.md_data = 32'h77;
        #1;
        chk("md_a0_ready_pre", bus.md_ready, 1'b1);
        tick();
        idle();
        chk("md_a0_ready_post", bus.md_ready, 1'b1);
        chk("md_a0_no_we_1",    bus.rf_we,    1'b0);
        tick();
        chk("md_a0_no_we_2",    bus.rf_we,    1'b0);

        // 6. Asynchronous reset with both buffers full and a write in flight
        bus.md_valid = 1'b1; bus.md_addr = 5'd11; bus.md_data = 32'h111;
        bus.io_valid = 1'b1; bus.io_addr = 5'd12; bus.io_data = 32'h222;
        bus.wb_we    = 1'b1; bus.wb_addr = 5'd4;  bus.wb_data = 32'h44;
        tick();
        idle();
        chk("pre_rst_we",       bus.rf_we,    1'b1);
        chk("pre_rst_md_ready", bus.md_ready, 1'b0);
        chk("pre_rst_io_ready", bus.io_ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rf_we",    bus.rf_we,    1'b0);
        chk("arst_rf_addr",  bus.rf_addr,  5'd0);
        chk("arst_md_ready", bus.md_ready, 1'b1);
        chk("arst_io_ready", bus.io_ready, 1'b1);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst_no_we_%0d", k), bus.rf_we, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between three requesters: pipeline writeback (wb), multiply/divide completion (md) and the IO/sensor capture path (io).
- md and io each have a one-entry holding buffer with a valid/ready handshake.
- Grants one write per cycle and drives a registered write strobe, address and data into the register file.
- Prevents md/io starvation by stalling writeback once a buffered request has aged out.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- STARVE_LIMIT, 4, wait cycles after which a buffered request forces a writeback stall.
- AGE_W, 3, age counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wb_we  in  1  writeback write request; no back-pressure except wb_stall.
- wb_addr  in  ADDR_W  writeback destination register.
- wb_data  in  DATA_W  writeback data.
- wb_stall  out  1  combinational; pipeline must hold wb_* while high.
- md_valid  in  1  multdiv result offered.
- md_ready  out  1  md buffer empty.
- md_addr  in  ADDR_W  multdiv destination register.
- md_data  in  DATA_W  multdiv result.
- io_valid  in  1  IO write offered.
- io_ready  out  1  io buffer empty.
- io_addr  in  ADDR_W  IO destination register.
- io_data  in  DATA_W  IO data.
- rf_we  out  1  register file write enable, registered.
- rf_addr  out  ADDR_W  register file write address, registered.
- rf_data  out  DATA_W  register file write data, registered.

Behaviour:
- Reset (asynchronous, active-high): md/io buffers empty, age counters 0, rf_we/rf_addr/rf_data = 0, wb_stall = 0, md_ready = io_ready = 1.
- Handshake: x_ready = !x_buf_valid, where x is md or io. On a clock edge with x_valid && x_ready the buffer loads addr/data.
  - No pass-through: a buffer drained in cycle N can accept again no earlier than cycle N+1.
- Address 0: a write to address 0 never reaches the port.
  - wb_we with wb_addr = 0 is ignored.
  - An md/io handshake with addr 0 completes, but the buffer is not loaded.
- starve = (md_buf_valid && md_age == STARVE_LIMIT) || (io_buf_valid && io_age == STARVE_LIMIT). wb_stall = starve.
- Grant per cycle, evaluated in this order, first match wins:
  1. starved md.
  2. starved io.
  3. wb (wb_we, addr != 0, !wb_stall).
  4. md buffer.
  5. io buffer.
  6. none.
- The granted buffer clears at the edge. Its age resets to 0.
- Age: each valid, ungranted buffer increments its age every cycle, saturating at STARVE_LIMIT. An empty buffer holds age 0.
- Output stage: at the edge, rf_we <= (grant != none); rf_addr/rf_data <= granted source.
  - When there is no grant, rf_addr/rf_data hold their previous value and rf_we = 0.
- Latency:
  - wb request in cycle N appears on rf_* in cycle N+1.
  - md/io handshake in cycle N: earliest grant is N+1, write appears at N+2.
- While wb_stall = 1 the wb request is not consumed. The pipeline re-presents it, and it is granted in the first cycle wb_stall = 0.
- Both buffers starved in the same cycle: md is granted first, wb_stall stays high, io is granted next cycle.
- No address-collision filtering: write order is purely grant order.
- Reset mid-operation: pending buffered writes are discarded and rf_we drops to 0 immediately, asynchronously.

Test Plan:
1. Reset release, idle inputs -> rf_we = 0, md_ready = io_ready = 1, wb_stall = 0, all outputs 0.
2. Cycle 1: wb_we = 1, wb_addr = 3, wb_data = 0xDEADBEEF -> cycle 2: rf_we = 1, rf_addr = 3, rf_data = 0xDEADBEEF.
3. Cycle 1: md_valid, addr 7, data 0x12; io_valid, addr 9, data 0x34; wb idle -> md_ready = 0 at cycle 2; rf writes r7 = 0x12 at cycle 3, r9 = 0x34 at cycle 4; both ready = 1 at cycle 4.
4. md buffered (addr 5, data 0xAA) while wb_we is asserted every cycle to addr 2 -> wb granted 4 cycles; md_age reaches 4; wb_stall = 1 for exactly one cycle; r5 = 0xAA written next cycle; then wb resumes with no lost write.
5. wb_addr = 0 with wb_we = 1; then md handshake with md_addr = 0 -> rf_we never asserts; md_ready returns to 1 the cycle after the handshake.
6. Both buffers full, then reset pulsed asynchronously mid-cycle -> rf_we = 0 and md_ready = io_ready = 1 immediately; no write after reset deasserts.
